memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 152 +++++++++++++++
 tb/tb_memory_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of a Y86-64 pipeline: M register plus a handshaked data-memory
// access FSM (IDLE/REQ/WAIT/DONE) with an ack-wait timeout.
module memory_stage #(
  parameter int DMEM_BYTES = 65536,
  parameter int MAX_WAIT   = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        bubble_i,
  input  logic [3:0]  icode_i,
  input  logic [2:0]  stat_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [3:0]  dstE_i,
  input  logic [3:0]  dstM_i,
  input  logic        cnd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [3:0]  icode_o,
  output logic [2:0]  stat_o,
  output logic [63:0] valE_o,
  output logic [63:0] valM_o,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o,
  output logic        busy_o
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVQ  = 4'h2;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] STAT_RESET  = 3'd0;
  localparam logic [2:0] STAT_OK     = 3'd1;
  localparam logic [2:0] STAT_ADR    = 3'd2;
  localparam logic [2:0] STAT_BUBBLE = 3'd5;

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_icode, r_dstE, r_dstM;
  logic [2:0]      r_stat;
  logic [63:0]     r_valE, r_valA, r_valM;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout, r_served;
  logic            w_rd, w_wr, w_legal, w_mem_ok, w_start, w_adr_fault;
  logic            w_upd, w_wait_last;
  logic [63:0]     w_addr;

  // M register: reset > hold (busy/stall) > bubble > load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_icode <= INOP;
      r_stat  <= STAT_RESET;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else if (w_upd && bubble_i) begin
      r_icode <= INOP;
      r_stat  <= STAT_BUBBLE;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else if (w_upd) begin
      r_icode <= icode_i;
      r_stat  <= stat_i;
      r_valE  <= valE_i;
      r_valA  <= valA_i;
      r_dstE  <= (icode_i == ICMOVQ && !cnd_i) ? RNONE : dstE_i;
      r_dstM  <= dstM_i;
    end
  end

  assign w_upd       = !(busy_o || stall_i);
  assign w_rd        = (r_icode == IMRMOVQ) || (r_icode == IPOPQ) || (r_icode == IRET);
  assign w_wr        = (r_icode == IRMMOVQ) || (r_icode == IPUSHQ) || (r_icode == ICALL);
  assign w_addr      = (r_icode == IPOPQ || r_icode == IRET) ? r_valA : r_valE;
  assign w_legal     = ({1'b0, w_addr} + 65'd7) < 65'(DMEM_BYTES);
  assign w_mem_ok    = (w_rd || w_wr) && (r_stat == STAT_OK);
  // r_served stops a held (stalled) instruction from being accessed twice
  assign w_start     = w_mem_ok && w_legal && !r_served;
  assign w_adr_fault = w_mem_ok && !w_legal;
  assign w_wait_last = (r_cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_REQ;
      S_REQ:  w_next = dmem_ack_i ? S_DONE : S_WAIT;
      S_WAIT: if (dmem_ack_i || w_wait_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o = (r_state == S_REQ);
    dmem_we_o  = (r_state == S_REQ) && w_wr;
    busy_o     = (r_state == S_REQ) || (r_state == S_WAIT) ||
                 ((r_state == S_IDLE) && w_start);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != S_WAIT) r_cnt <= '0;
    else                            r_cnt <= r_cnt + CW'(1);
  end

  // Access results live until the M register takes its next instruction
  always_ff @(posedge clk_i) begin
    if (rst_i || w_upd) begin
      r_valM    <= '0;
      r_timeout <= 1'b0;
      r_served  <= 1'b0;
    end else begin
      if ((r_state == S_REQ || r_state == S_WAIT) && dmem_ack_i && w_rd)
        r_valM <= dmem_rdata_i;
      if (r_state == S_WAIT && !dmem_ack_i && w_wait_last)
        r_timeout <= 1'b1;
      if (r_state == S_DONE)
        r_served <= 1'b1;
    end
  end

  assign dmem_addr_o  = w_addr;
  assign dmem_wdata_o = r_valA;
  assign icode_o      = r_icode;
  assign stat_o       = (r_timeout || w_adr_fault) ? STAT_ADR : r_stat;
  assign valE_o       = r_valE;
  assign valM_o       = w_rd ? r_valM : 64'd0;
  assign dstE_o       = r_dstE;
  assign dstM_o       = r_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: register behaviour, read/write
// handshakes, address faults, timeout, mid-transaction reset, bubble and stall.
module tb_memory_stage;

  localparam logic [3:0] INOP = 4'h1, ICMOVQ = 4'h2, IIRMOVQ = 4'h3, IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5, IOPQ = 4'h6, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam logic [2:0] S_RESET = 3'd0, S_OK = 3'd1, S_ADR = 3'd2, S_HLT = 3'd4, S_BUB = 3'd5;

  logic        clk = 0, rst = 0, stall = 0, bubble = 0;
  logic [3:0]  icode_i, dstE_i, dstM_i;
  logic [2:0]  stat_i;
  logic [63:0] valE_i, valA_i, rdata = 0;
  logic        cnd_i, ack = 0;
  logic        req, we, busy;
  logic [63:0] addr, wdata, valE_o, valM_o;
  logic [3:0]  icode_o, dstE_o, dstM_o;
  logic [2:0]  stat_o;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(.DMEM_BYTES(65536), .MAX_WAIT(15)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
    .icode_i(icode_i), .stat_i(stat_i), .valE_i(valE_i), .valA_i(valA_i),
    .dstE_i(dstE_i), .dstM_i(dstM_i), .cnd_i(cnd_i),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_rdata_i(rdata), .dmem_ack_i(ack),
    .icode_o(icode_o), .stat_o(stat_o), .valE_o(valE_o), .valM_o(valM_o),
    .dstE_o(dstE_o), .dstM_o(dstM_o), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                        input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                        input logic c);
    icode_i = ic; stat_i = st; valE_i = ve; valA_i = va; dstE_i = de; dstM_i = dm; cnd_i = c;
  endtask

  task automatic set_nop();
    set_in(INOP, S_OK, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_checks++; if (stat_o !== S_RESET) begin n_fail++; $display("FAIL rst_stat got %0d exp %0d", stat_o, S_RESET); end
    n_checks++; if (icode_o !== INOP) begin n_fail++; $display("FAIL rst_icode got %0h exp %0h", icode_o, INOP); end
    n_checks++; if (valE_o !== 64'd0 || valM_o !== 64'd0) begin n_fail++; $display("FAIL rst_vals got %0h/%0h exp 0/0", valE_o, valM_o); end
    n_checks++; if (dstE_o !== 4'hF || dstM_o !== 4'hF) begin n_fail++; $display("FAIL rst_dst got %0h/%0h exp f/f", dstE_o, dstM_o); end
    n_checks++; if (busy !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL rst_busy_req got %0b/%0b exp 0/0", busy, req); end
  endtask

  task automatic test_nonmem();
    set_in(IOPQ, S_OK, 64'h1234, 64'h9, 4'h3, 4'hF, 1'b1); tick(); set_nop();
    n_checks++; if (icode_o !== IOPQ || valE_o !== 64'h1234 || dstE_o !== 4'h3) begin n_fail++; $display("FAIL opq_out got %0h/%0h/%0h exp 6/1234/3", icode_o, valE_o, dstE_o); end
    n_checks++; if (stat_o !== S_OK || busy !== 1'b0 || valM_o !== 64'd0 || req !== 1'b0) begin n_fail++; $display("FAIL opq_ctl got stat %0d busy %0b valM %0h req %0b exp 1/0/0/0", stat_o, busy, valM_o, req); end
    set_in(ICMOVQ, S_OK, 64'h5, 64'h5, 4'h5, 4'hF, 1'b0); tick();
    n_checks++; if (dstE_o !== 4'hF) begin n_fail++; $display("FAIL cmov_nc_dstE got %0h exp f", dstE_o); end
    set_in(ICMOVQ, S_OK, 64'h5, 64'h5, 4'h5, 4'hF, 1'b1); tick(); set_nop();
    n_checks++; if (dstE_o !== 4'h5) begin n_fail++; $display("FAIL cmov_c_dstE got %0h exp 5", dstE_o); end
  endtask

  task automatic test_read();
    int nbusy = 0, nreq = 0;
    set_in(IMRMOVQ, S_OK, 64'h100, 64'h0, 4'hF, 4'h4, 1'b1); tick(); set_nop();
    nbusy += int'(busy); nreq += int'(req);
    n_checks++; if (busy !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL rd_idle got busy %0b req %0b exp 1/0", busy, req); end
    tick(); nbusy += int'(busy); nreq += int'(req);
    n_checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 64'h100) begin n_fail++; $display("FAIL rd_req got req %0b we %0b addr %0h exp 1/0/100", req, we, addr); end
    tick(); nbusy += int'(busy); nreq += int'(req);
    ack = 1; rdata = 64'hDEADBEEF;
    tick(); ack = 0; rdata = 0;
    nbusy += int'(busy); nreq += int'(req);
    n_checks++; if (valM_o !== 64'hDEADBEEF || stat_o !== S_OK || icode_o !== IMRMOVQ || dstM_o !== 4'h4) begin n_fail++; $display("FAIL rd_done got valM %0h stat %0d icode %0h dstM %0h exp deadbeef/1/5/4", valM_o, stat_o, icode_o, dstM_o); end
    n_checks++; if (nbusy !== 3 || nreq !== 1) begin n_fail++; $display("FAIL rd_counts got busy %0d req %0d exp 3/1", nbusy, nreq); end
    tick();
    n_checks++; if (icode_o !== INOP || valM_o !== 64'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_next got icode %0h valM %0h busy %0b exp 1/0/0", icode_o, valM_o, busy); end
  endtask

  task automatic test_push();
    set_in(IPUSHQ, S_OK, 64'h1F8, 64'h55, 4'h4, 4'hF, 1'b1); tick(); set_nop();
    tick();
    n_checks++; if (req !== 1'b1 || we !== 1'b1 || addr !== 64'h1F8 || wdata !== 64'h55) begin n_fail++; $display("FAIL push_req got req %0b we %0b addr %0h wdata %0h exp 1/1/1f8/55", req, we, addr, wdata); end
    ack = 1; tick(); ack = 0;
    n_checks++; if (busy !== 1'b0 || req !== 1'b0 || stat_o !== S_OK || valM_o !== 64'd0) begin n_fail++; $display("FAIL push_done got busy %0b req %0b stat %0d valM %0h exp 0/0/1/0", busy, req, stat_o, valM_o); end
    tick();
    n_checks++; if (icode_o !== INOP) begin n_fail++; $display("FAIL push_next got %0h exp 1", icode_o); end
  endtask

  task automatic test_addr_bounds();
    set_in(IRMMOVQ, S_OK, 64'hFFFC, 64'h1, 4'hF, 4'hF, 1'b1); tick(); set_nop();
    n_checks++; if (busy !== 1'b0 || req !== 1'b0 || stat_o !== S_ADR) begin n_fail++; $display("FAIL illegal got busy %0b req %0b stat %0d exp 0/0/2", busy, req, stat_o); end
    tick();
    n_checks++; if (stat_o !== S_OK || icode_o !== INOP || busy !== 1'b0) begin n_fail++; $display("FAIL illegal_next got stat %0d icode %0h busy %0b exp 1/1/0", stat_o, icode_o, busy); end
    set_in(IRMMOVQ, S_OK, 64'hFFF8, 64'h1, 4'hF, 4'hF, 1'b1); tick(); set_nop();
    n_checks++; if (busy !== 1'b1 || stat_o !== S_OK) begin n_fail++; $display("FAIL edge_legal got busy %0b stat %0d exp 1/1", busy, stat_o); end
    tick(); ack = 1; tick(); ack = 0; tick();
    set_in(IMRMOVQ, S_HLT, 64'h10, 64'h0, 4'hF, 4'h2, 1'b1); tick(); set_nop();
    n_checks++; if (busy !== 1'b0 || req !== 1'b0 || stat_o !== S_HLT) begin n_fail++; $display("FAIL stat_pass got busy %0b req %0b stat %0d exp 0/0/4", busy, req, stat_o); end
    tick();
  endtask

  task automatic test_pop_and_stray_ack();
    set_in(IPOPQ, S_OK, 64'h48, 64'h40, 4'h4, 4'h3, 1'b1); tick(); set_nop();
    tick();
    n_checks++; if (req !== 1'b1 || addr !== 64'h40 || we !== 1'b0) begin n_fail++; $display("FAIL pop_req got req %0b addr %0h we %0b exp 1/40/0", req, addr, we); end
    ack = 1; rdata = 64'h77; tick(); rdata = 64'h99;
    n_checks++; if (valM_o !== 64'h77 || valE_o !== 64'h48) begin n_fail++; $display("FAIL pop_done got valM %0h valE %0h exp 77/48", valM_o, valE_o); end
    tick(); tick(); ack = 0; rdata = 0;
    n_checks++; if (valM_o !== 64'd0 || busy !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL stray_ack got valM %0h busy %0b req %0b exp 0/0/0", valM_o, busy, req); end
  endtask

  task automatic test_timeout();
    int nwait = 0;
    set_in(IMRMOVQ, S_OK, 64'h200, 64'h0, 4'hF, 4'h1, 1'b1); tick(); set_nop();
    tick();
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL to_req got %0b exp 1", req); end
    tick();
    while (busy === 1'b1 && nwait < 40) begin
      if (req !== 1'b0) begin n_checks++; n_fail++; $display("FAIL to_wait_req got %0b exp 0", req); end
      nwait++; tick();
    end
    n_checks++; if (nwait !== 15) begin n_fail++; $display("FAIL to_wait_cycles got %0d exp 15", nwait); end
    n_checks++; if (stat_o !== S_ADR || valM_o !== 64'd0) begin n_fail++; $display("FAIL to_stat got stat %0d valM %0h exp 2/0", stat_o, valM_o); end
    tick();
    n_checks++; if (stat_o !== S_OK || busy !== 1'b0 || icode_o !== INOP) begin n_fail++; $display("FAIL to_idle got stat %0d busy %0b icode %0h exp 1/0/1", stat_o, busy, icode_o); end
  endtask

  task automatic test_reset_mid();
    set_in(IMRMOVQ, S_OK, 64'h300, 64'h0, 4'hF, 4'h1, 1'b1); tick(); set_nop();
    tick(); tick();
    rst = 1; tick(); rst = 0;
    stall = 1; ack = 1; rdata = 64'hCAFE;
    n_checks++; if (stat_o !== S_RESET || busy !== 1'b0 || req !== 1'b0 || icode_o !== INOP || dstE_o !== 4'hF || valE_o !== 64'd0) begin n_fail++; $display("FAIL rmid_rst got stat %0d busy %0b req %0b icode %0h exp 0/0/0/1", stat_o, busy, req, icode_o); end
    tick(); ack = 0; rdata = 0;
    n_checks++; if (stat_o !== S_RESET || valM_o !== 64'd0 || req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ack got stat %0d valM %0h req %0b busy %0b exp 0/0/0/0", stat_o, valM_o, req, busy); end
    stall = 0; tick();
  endtask

  task automatic test_bubble_stall();
    set_in(IOPQ, S_OK, 64'h77, 64'h0, 4'h2, 4'hF, 1'b1); tick();
    bubble = 1; tick(); bubble = 0;
    n_checks++; if (stat_o !== S_BUB || dstE_o !== 4'hF || icode_o !== INOP || valE_o !== 64'd0) begin n_fail++; $display("FAIL bubble got stat %0d dstE %0h icode %0h valE %0h exp 5/f/1/0", stat_o, dstE_o, icode_o, valE_o); end
    set_in(IIRMOVQ, S_OK, 64'h99, 64'h0, 4'h6, 4'hF, 1'b1); tick();
    set_in(IOPQ, S_OK, 64'hAAAA, 64'h0, 4'h1, 4'hF, 1'b1);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (icode_o !== IIRMOVQ || valE_o !== 64'h99 || dstE_o !== 4'h6) begin n_fail++; $display("FAIL stall_hold%0d got %0h/%0h/%0h exp 3/99/6", i, icode_o, valE_o, dstE_o); end
    end
    stall = 0; tick(); set_nop();
    n_checks++; if (icode_o !== IOPQ || valE_o !== 64'hAAAA || dstE_o !== 4'h1) begin n_fail++; $display("FAIL stall_release got %0h/%0h/%0h exp 6/aaaa/1", icode_o, valE_o, dstE_o); end
  endtask

  initial begin
    set_nop();
    test_reset();
    test_nonmem();
    test_read();
    test_push();
    test_addr_bounds();
    test_pop_and_stray_ack();
    test_timeout();
    test_reset_mid();
    test_bubble_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
